// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor control blocks: increment-register
// control codes and the fetch sequencer state encoding.
package proc_ctrl_pkg;

    localparam logic [1:0] CTRL_STORE = 2'b00;
    localparam logic [1:0] CTRL_LOAD  = 2'b01;
    localparam logic [1:0] CTRL_INCR  = 2'b10;
    localparam logic [1:0] CTRL_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_FETCH = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4,
        ST_FAULT = 3'd5
    } seq_state_e;

endpackage

// File: rtl/fetch_timer.sv
// Counts consecutive FETCH cycles without a memory acknowledge; expired_o
// flags the last permitted wait cycle.
module fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int         W    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer: drives PC/IR register controls, the instruction memory
// request/ack handshake and the decoder valid/ready handshake.
module pc_seq_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       mem_req,
    input  logic       mem_ack,
    output logic [1:0] ir_ctrl,
    output logic [1:0] pc_ctrl,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       branch_take,
    input  logic       halt_req,
    output logic       busy,
    output logic       fault
);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       tmr_clr;
    logic       tmr_en;
    logic       tmr_expired;

    // Timer is held at zero outside FETCH, so every FETCH entry starts fresh.
    assign tmr_clr = rst || (state_q != ST_FETCH);
    assign tmr_en  = (state_q == ST_FETCH) && !mem_ack;

    fetch_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: state_d = ST_IDLE;
            ST_IDLE:  if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                // An ack on the final wait cycle still wins over the fault.
                if (mem_ack) begin
                    state_d = ST_ISSUE;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (run) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT:  if (!run) state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        busy        = 1'b0;
        fault       = 1'b0;
        pc_ctrl     = CTRL_STORE;
        ir_ctrl     = CTRL_STORE;
        if (rst) begin
            pc_ctrl = CTRL_CLEAR;
            ir_ctrl = CTRL_CLEAR;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    busy    = 1'b1;
                    if (mem_ack) ir_ctrl = CTRL_LOAD;
                end
                ST_ISSUE: begin
                    instr_valid = 1'b1;
                    busy        = 1'b1;
                    if (instr_ready && !halt_req) begin
                        pc_ctrl = branch_take ? CTRL_LOAD : CTRL_INCR;
                    end
                end
                ST_FAULT: fault = 1'b1;
                ST_IDLE, ST_HALT: ;
                default: begin
                    pc_ctrl = CTRL_CLEAR;
                    ir_ctrl = CTRL_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed vector table, a hand-written stall/reset
// sequence and a randomized run against a behavioural model.
module tb_pc_seq_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       mem_ack = 1'b0;
    logic       instr_ready = 1'b0;
    logic       branch_take = 1'b0;
    logic       halt_req = 1'b0;
    logic       mem_req;
    logic [1:0] ir_ctrl;
    logic [1:0] pc_ctrl;
    logic       instr_valid;
    logic       busy;
    logic       fault;

    int tests = 0;
    int fails = 0;

    pc_seq_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .ir_ctrl    (ir_ctrl),
        .pc_ctrl    (pc_ctrl),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .branch_take(branch_take),
        .halt_req   (halt_req),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase name plus a plain count of unanswered fetch cycles.
    typedef enum int {M_CLR, M_IDLE, M_FETCH, M_ISSUE, M_HALT, M_FAULT} mph_t;
    mph_t m_ph = M_CLR;
    int   m_waits = 0;

    // Packed output word: {mem_req, pc_ctrl, ir_ctrl, instr_valid, busy, fault}
    function automatic logic [7:0] E(bit mr, int pc, int ir, bit v, bit b, bit f);
        logic [1:0] p;
        logic [1:0] i;
        p = pc[1:0];
        i = ir[1:0];
        return {mr, p, i, v, b, f};
    endfunction

    function automatic logic [7:0] model_out();
        if (rst) return E(0, 3, 3, 0, 0, 0);
        case (m_ph)
            M_CLR:   return E(0, 3, 3, 0, 0, 0);
            M_FETCH: return E(1, 0, mem_ack ? 1 : 0, 0, 1, 0);
            M_ISSUE: begin
                int pc;
                pc = 0;
                if (instr_ready && !halt_req) pc = branch_take ? 1 : 2;
                return E(0, pc, 0, 1, 1, 0);
            end
            M_FAULT: return E(0, 0, 0, 0, 0, 1);
            default: return E(0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    task automatic model_step();
        if (rst) begin
            m_ph = M_CLR;
            return;
        end
        case (m_ph)
            M_CLR:  m_ph = M_IDLE;
            M_IDLE: if (run) begin m_ph = M_FETCH; m_waits = 0; end
            M_FETCH: begin
                if (mem_ack) m_ph = M_ISSUE;
                else begin
                    m_waits = m_waits + 1;
                    if (m_waits >= TO) m_ph = M_FAULT;
                end
            end
            M_ISSUE: if (instr_ready) begin
                if (halt_req) m_ph = M_HALT;
                else if (run) begin m_ph = M_FETCH; m_waits = 0; end
                else m_ph = M_IDLE;
            end
            M_HALT: if (!run) m_ph = M_IDLE;
            default: ;
        endcase
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {req,pc,ir,vld,busy,flt}=%b expected %b", nm, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, compare 1ns later, advance on the rising edge.
    task automatic cycle(input logic r, input logic ru, input logic ak, input logic rd,
                         input logic b, input logic h, input bit use_exp,
                         input logic [7:0] exp, input string nm);
        logic [7:0] act;
        @(negedge clk);
        rst = r; run = ru; mem_ack = ak; instr_ready = rd; branch_take = b; halt_req = h;
        #1;
        act = {mem_req, pc_ctrl, ir_ctrl, instr_valid, busy, fault};
        if (use_exp) chk(nm, act, exp);
        else chk(nm, act, model_out());
        model_step();
        @(posedge clk);
    endtask

    typedef struct {
        logic r, ru, ak, rd, b, h;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic ru, input logic ak, input logic rd,
                       input logic b, input logic h, input logic [7:0] exp);
        vec_t v;
        v.r = r; v.ru = ru; v.ak = ak; v.rd = rd; v.b = b; v.h = h; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        // reset held two cycles, CLEAR, IDLE, then first fetch
        add(1,1,0,0,0,0, E(0,3,3,0,0,0));
        add(1,1,0,0,0,0, E(0,3,3,0,0,0));
        add(0,1,0,0,0,0, E(0,3,3,0,0,0));
        add(0,1,0,0,0,0, E(0,0,0,0,0,0));
        // four zero-wait instructions, always-ready decoder
        for (int i = 0; i < 4; i++) begin
            add(0,1,1,0,0,0, E(1,0,1,0,1,0));
            add(0,1,0,1,0,0, E(0,2,0,1,1,0));
        end
        // taken branch, then halt beating branch
        add(0,1,1,0,0,0, E(1,0,1,0,1,0));
        add(0,1,0,1,1,0, E(0,1,0,1,1,0));
        add(0,1,1,0,0,0, E(1,0,1,0,1,0));
        add(0,1,0,1,1,1, E(0,0,0,1,1,0));
        add(0,1,1,0,0,0, E(0,0,0,0,0,0));  // HALT ignores ack
        add(0,1,0,0,0,0, E(0,0,0,0,0,0));
        add(0,0,0,0,0,0, E(0,0,0,0,0,0));  // drop run -> IDLE
        add(0,0,0,0,0,0, E(0,0,0,0,0,0));
        add(0,1,0,0,0,0, E(0,0,0,0,0,0));
        // ack on the 4th wait cycle
        add(0,1,0,0,0,0, E(1,0,0,0,1,0));
        add(0,1,0,0,0,0, E(1,0,0,0,1,0));
        add(0,1,0,0,0,0, E(1,0,0,0,1,0));
        add(0,1,1,0,0,0, E(1,0,1,0,1,0));
        add(0,0,0,1,0,0, E(0,2,0,1,1,0));  // accept with run=0 -> IDLE
        add(0,1,1,0,0,0, E(0,0,0,0,0,0));
        // no ack for 4 cycles -> fault, sticky
        add(0,1,0,0,0,0, E(1,0,0,0,1,0));
        add(0,1,0,0,0,0, E(1,0,0,0,1,0));
        add(0,1,0,0,0,0, E(1,0,0,0,1,0));
        add(0,1,0,0,0,0, E(1,0,0,0,1,0));
        add(0,1,1,1,0,0, E(0,0,0,0,0,1));
        add(0,0,1,1,0,0, E(0,0,0,0,0,1));
        add(0,1,0,0,0,0, E(0,0,0,0,0,1));
        add(1,1,0,0,0,0, E(0,3,3,0,0,0));
        add(0,1,0,0,0,0, E(0,3,3,0,0,0));
        add(0,1,0,0,0,0, E(0,0,0,0,0,0));
        add(0,1,1,0,0,0, E(1,0,1,0,1,0));

        foreach (tbl[i])
            cycle(tbl[i].r, tbl[i].ru, tbl[i].ak, tbl[i].rd, tbl[i].b, tbl[i].h,
                  1'b1, tbl[i].exp, $sformatf("vec%0d", i));

        // decoder stall for 6 cycles, then accept
        for (int i = 0; i < 6; i++)
            cycle(0,1,1,0,1,0, 1'b1, E(0,0,0,1,1,0), $sformatf("stall%0d", i));
        cycle(0,1,0,1,0,0, 1'b1, E(0,2,0,1,1,0), "stall_accept");
        cycle(0,1,1,0,0,0, 1'b1, E(1,0,1,0,1,0), "refetch");
        // reset in the 3rd stall cycle aborts the issue
        cycle(0,1,0,0,0,0, 1'b1, E(0,0,0,1,1,0), "stall_a");
        cycle(0,1,0,0,0,0, 1'b1, E(0,0,0,1,1,0), "stall_b");
        cycle(1,1,0,1,0,0, 1'b1, E(0,3,3,0,0,0), "stall_rst");
        cycle(0,1,0,1,0,0, 1'b1, E(0,3,3,0,0,0), "after_rst_clear");
        cycle(0,1,0,0,0,0, 1'b1, E(0,0,0,0,0,0), "after_rst_idle");

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                  1'b0, 8'h00, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
